// File: rtl/dest_scoreboard.sv
// dest_scoreboard: decodes the MIPS destination register and tracks in-flight writes
// in a fixed-depth shift pipeline. Define WB_BYPASS_EN to drop the write-back stage from hazard checks.
module dest_scoreboard #(
  parameter  int NREG  = 32,
  parameter  int DEPTH = 3,
  localparam int RW    = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            issue_valid,
  input  logic [31:0]     instruction,
  input  logic            flush,
  output logic            issue_ready,
  output logic [RW-1:0]   dest_reg,
  output logic            illegal,
  output logic            wb_valid,
  output logic [RW-1:0]   wb_reg,
  output logic [NREG-1:0] busy
);

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_REGIMM  = 6'h01;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_BLEZ    = 6'h06;
  localparam logic [5:0] OP_BGTZ    = 6'h07;
  localparam logic [5:0] OP_ADDI    = 6'h08;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_SLTI    = 6'h0A;
  localparam logic [5:0] OP_SLTIU   = 6'h0B;
  localparam logic [5:0] OP_ANDI    = 6'h0C;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_XORI    = 6'h0E;
  localparam logic [5:0] OP_LUI     = 6'h0F;
  localparam logic [5:0] OP_LB      = 6'h20;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_LBU     = 6'h24;
  localparam logic [5:0] OP_SB      = 6'h28;
  localparam logic [5:0] OP_SW      = 6'h2B;
  localparam logic [5:0] FN_JR      = 6'h08;
  localparam logic [4:0] RI_BLTZAL  = 5'h10;
  localparam logic [4:0] RI_BGEZAL  = 5'h11;

  // Register 31 truncated to RW bits is all ones for every legal NREG.
  localparam logic [RW-1:0] LINK_REG = {RW{1'b1}};

`ifdef WB_BYPASS_EN
  localparam int HAZ_STAGES = DEPTH - 1;
`else
  localparam int HAZ_STAGES = DEPTH;
`endif

  logic [5:0]            w_opcode;
  logic [5:0]            w_funct;
  logic [4:0]            w_regimmRt;
  logic [RW-1:0]         w_rs;
  logic [RW-1:0]         w_rt;
  logic [RW-1:0]         w_rd;
  logic [RW-1:0]         w_dest;
  logic                  w_legal;
  logic                  w_usesRt;
  logic [NREG-1:0]       w_hazardMask;
  logic [NREG-1:0]       w_busyMask;
  logic                  w_stall;
  logic                  w_unused;
  logic [DEPTH-1:0]          r_stageValid;
  logic [DEPTH-1:0][RW-1:0]  r_stageReg;

  assign w_opcode   = instruction[31:26];
  assign w_funct    = instruction[5:0];
  assign w_regimmRt = instruction[20:16];
  assign w_rs       = instruction[21 +: RW];
  assign w_rt       = instruction[16 +: RW];
  assign w_rd       = instruction[11 +: RW];
  assign w_unused   = ^instruction;

  always_comb begin
    w_dest   = '0;
    w_legal  = 1'b1;
    w_usesRt = 1'b0;
    case (w_opcode)
      OP_SPECIAL: begin
        w_usesRt = 1'b1;
        if (w_funct != FN_JR) w_dest = w_rd;
      end
      OP_REGIMM: begin
        if (w_regimmRt == RI_BLTZAL || w_regimmRt == RI_BGEZAL) w_dest = LINK_REG;
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI,
      OP_LB, OP_LW, OP_LBU: begin
        w_dest = w_rt;
      end
      OP_BEQ, OP_BNE, OP_SB, OP_SW: begin
        w_usesRt = 1'b1;
      end
      OP_J, OP_BLEZ, OP_BGTZ: begin
        w_dest = '0;
      end
      OP_JAL: begin
        w_dest = LINK_REG;
      end
      default: begin
        w_legal = 1'b0;
      end
    endcase
  end

  // Registers with a pending write in the stages that still block a reader.
  always_comb begin
    w_hazardMask = '0;
    for (int i = 0; i < HAZ_STAGES; i++) begin
      if (r_stageValid[i]) w_hazardMask[r_stageReg[i]] = 1'b1;
    end
    w_hazardMask[0] = 1'b0;
  end

  always_comb begin
    w_busyMask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_stageValid[i]) w_busyMask[r_stageReg[i]] = 1'b1;
    end
    w_busyMask[0] = 1'b0;
  end

  assign w_stall     = issue_valid & (w_hazardMask[w_rs] | (w_usesRt & w_hazardMask[w_rt]));
  assign issue_ready = issue_valid & ~w_stall & ~flush;
  assign dest_reg    = w_dest;
  assign illegal     = issue_valid & ~w_legal;
  assign busy        = w_busyMask;
  assign wb_valid    = r_stageValid[DEPTH-1];
  assign wb_reg      = r_stageReg[DEPTH-1];

  // No back-pressure: the pipeline shifts every cycle, flush empties it at the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stageValid <= '0;
      r_stageReg   <= '0;
    end else if (flush) begin
      r_stageValid <= '0;
      r_stageReg   <= '0;
    end else begin
      r_stageValid[0] <= issue_ready;
      r_stageReg[0]   <= issue_ready ? w_dest : '0;
      for (int i = 1; i < DEPTH; i++) begin
        r_stageValid[i] <= r_stageValid[i-1];
        r_stageReg[i]   <= r_stageReg[i-1];
      end
    end
  end

endmodule

// File: tb/tb_dest_scoreboard.sv
// Testbench for dest_scoreboard: directed scenarios followed by random traffic,
// every cycle checked against a queue-based model of in-flight writes.
module tb_dest_scoreboard;

  localparam int NREG  = 32;
  localparam int DEPTH = 3;
  localparam int RW    = 5;

`ifdef WB_BYPASS_EN
  localparam int HAZ_END    = DEPTH - 1;
  localparam int EXP_ACCEPT = 3;
`else
  localparam int HAZ_END    = DEPTH;
  localparam int EXP_ACCEPT = 4;
`endif

  localparam logic [31:0] ADDI8  = 32'h20080005;
  localparam logic [31:0] ADD9   = 32'h01084820;
  localparam logic [31:0] JAL0   = 32'h0C000000;
  localparam logic [31:0] JR31   = 32'h03E00008;
  localparam logic [31:0] BADOP  = 32'hFC000000;

  logic            clk;
  logic            reset;
  logic            issue_valid;
  logic [31:0]     instruction;
  logic            flush;
  logic            issue_ready;
  logic [RW-1:0]   dest_reg;
  logic            illegal;
  logic            wb_valid;
  logic [RW-1:0]   wb_reg;
  logic [NREG-1:0] busy;

  dest_scoreboard #(.NREG(NREG), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .issue_valid(issue_valid), .instruction(instruction),
    .flush(flush), .issue_ready(issue_ready), .dest_reg(dest_reg), .illegal(illegal),
    .wb_valid(wb_valid), .wb_reg(wb_reg), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] dest;
    int         acc;
  } entry_t;

  entry_t flight[$];
  int     cyc;
  int     checks;
  int     errors;
  logic   expReady;
  logic [4:0] expDest;
  logic            lastReady;
  logic            lastWb;
  logic [RW-1:0]   lastDest;
  logic [RW-1:0]   lastWbReg;
  logic            lastIllegal;
  logic [NREG-1:0] lastBusy;

  logic [5:0] opTable [26] = '{6'h00, 6'h00, 6'h00, 6'h01, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05,
                               6'h06, 6'h07, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E,
                               6'h0F, 6'h20, 6'h23, 6'h24, 6'h28, 6'h2B, 6'h3F, 6'h10};

  task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Destination table of the supported MIPS subset.
  function automatic void decodeModel(input logic [31:0] ins, output logic [4:0] dest,
                                      output bit legal, output bit usesRt);
    logic [5:0] op;
    logic [4:0] rt;
    logic [4:0] rd;
    logic [5:0] fn;
    op = ins[31:26];
    rt = ins[20:16];
    rd = ins[15:11];
    fn = ins[5:0];
    dest = 5'd0;
    legal = 1'b1;
    usesRt = 1'b0;
    case (op)
      6'h00: begin usesRt = 1'b1; dest = (fn == 6'h08) ? 5'd0 : rd; end
      6'h01: dest = (rt == 5'h10 || rt == 5'h11) ? 5'd31 : 5'd0;
      6'h02, 6'h06, 6'h07: dest = 5'd0;
      6'h03: dest = 5'd31;
      6'h04, 6'h05, 6'h28, 6'h2B: usesRt = 1'b1;
      6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h20, 6'h23, 6'h24: dest = rt;
      default: legal = 1'b0;
    endcase
  endfunction

  // An entry accepted in cycle a is pending in cycles a+1..a+DEPTH and retires in a+DEPTH.
  task automatic checkOutput();
    bit lg;
    bit ur;
    bit stall;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [NREG-1:0] eBusy;
    logic [NREG-1:0] eHaz;
    logic eWb;
    logic [4:0] eWbReg;
    decodeModel(instruction, expDest, lg, ur);
    rs = instruction[25:21];
    rt = instruction[20:16];
    eBusy = '0;
    eHaz = '0;
    eWb = 1'b0;
    eWbReg = 5'd0;
    foreach (flight[k]) begin
      if (cyc >= flight[k].acc + 1 && cyc <= flight[k].acc + DEPTH && flight[k].dest != 0)
        eBusy[flight[k].dest] = 1'b1;
      if (cyc >= flight[k].acc + 1 && cyc <= flight[k].acc + HAZ_END && flight[k].dest != 0)
        eHaz[flight[k].dest] = 1'b1;
      if (cyc == flight[k].acc + DEPTH) begin
        eWb = 1'b1;
        eWbReg = flight[k].dest;
      end
    end
    stall = issue_valid && ((rs != 0 && eHaz[rs]) || (ur && rt != 0 && eHaz[rt]));
    expReady = issue_valid && !stall && !flush;
    lastReady = issue_ready;
    lastWb = wb_valid;
    lastDest = dest_reg;
    lastWbReg = wb_reg;
    lastIllegal = illegal;
    lastBusy = busy;
    checkEq("dest_reg", 32'(dest_reg), 32'(expDest));
    checkEq("illegal", 32'(illegal), 32'(issue_valid && !lg));
    checkEq("issue_ready", 32'(issue_ready), 32'(expReady));
    checkEq("wb_valid", 32'(wb_valid), 32'(eWb));
    checkEq("wb_reg", 32'(wb_reg), 32'(eWbReg));
    checkEq("busy", 32'(busy), 32'(eBusy));
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] ins, input logic fl);
    issue_valid = v;
    instruction = ins;
    flush = fl;
    @(negedge clk);
    checkOutput();
    @(posedge clk);
    if (fl) flight.delete();
    else if (expReady) flight.push_back('{expDest, cyc});
    cyc++;
    while (flight.size() > 0 && flight[0].acc + DEPTH < cyc) void'(flight.pop_front());
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 32'h0, 1'b0);
  endtask

  logic [31:0] randIns;
  int waitCyc;
  bit accepted;
  int pulses;
  logic busyRun;

  initial begin
    checks = 0;
    errors = 0;
    cyc = 0;
    reset = 1'b1;
    issue_valid = 1'b0;
    instruction = 32'h0;
    flush = 1'b0;
    #3;
    checkEq("reset_busy", 32'(busy), 32'h0);
    checkEq("reset_wb_valid", 32'(wb_valid), 32'h0);
    checkEq("reset_wb_reg", 32'(wb_reg), 32'h0);
    @(posedge clk);
    #3;
    reset = 1'b0;

    $display("[TB] single addi $8");
    applyStimulus(1'b1, ADDI8, 1'b0);
    checkEq("addi_dest", 32'(lastDest), 32'd8);
    checkEq("addi_ready", 32'(lastReady), 32'd1);
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkEq("addi_busy_c1", 32'(lastBusy[8]), 32'd1);
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkEq("addi_busy_c2", 32'(lastBusy[8]), 32'd1);
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkEq("addi_busy_c3", 32'(lastBusy[8]), 32'd1);
    checkEq("addi_wb_c3", 32'(lastWb), 32'd1);
    checkEq("addi_wbreg_c3", 32'(lastWbReg), 32'd8);
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkEq("addi_busy_c4", 32'(lastBusy[8]), 32'd0);
    idle(2);

    $display("[TB] RAW hazard addi -> add");
    applyStimulus(1'b1, ADDI8, 1'b0);
    waitCyc = 1;
    accepted = 0;
    while (!accepted && waitCyc <= 8) begin
      applyStimulus(1'b1, ADD9, 1'b0);
      if (lastReady) accepted = 1;
      else waitCyc++;
    end
    checkEq("add_accept_cycle", 32'(waitCyc), 32'(EXP_ACCEPT));
    idle(5);

    $display("[TB] jal / jr");
    applyStimulus(1'b1, JAL0, 1'b0);
    checkEq("jal_dest", 32'(lastDest), 32'd31);
    applyStimulus(1'b1, JR31, 1'b0);
    checkEq("jr_dest", 32'(lastDest), 32'd0);
    checkEq("jr_stall", 32'(lastReady), 32'd0);
    waitCyc = 2;
    accepted = 0;
    while (!accepted && waitCyc <= 8) begin
      applyStimulus(1'b1, JR31, 1'b0);
      if (lastReady) accepted = 1;
      else waitCyc++;
    end
    checkEq("jr_accept_cycle", 32'(waitCyc), 32'(EXP_ACCEPT));
    idle(5);

    $display("[TB] WAW back-to-back addi $8");
    pulses = 0;
    busyRun = 1'b1;
    applyStimulus(1'b1, ADDI8, 1'b0);
    pulses += int'(lastWb);
    applyStimulus(1'b1, ADDI8, 1'b0);
    pulses += int'(lastWb);
    busyRun &= lastBusy[8];
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 32'h0, 1'b0);
      pulses += int'(lastWb);
      busyRun &= lastBusy[8];
    end
    applyStimulus(1'b0, 32'h0, 1'b0);
    pulses += int'(lastWb);
    checkEq("waw_busy_clear", 32'(lastBusy[8]), 32'd0);
    applyStimulus(1'b0, 32'h0, 1'b0);
    pulses += int'(lastWb);
    checkEq("waw_busy_held", 32'(busyRun), 32'd1);
    checkEq("waw_wb_pulses", 32'(pulses), 32'd2);
    idle(2);

    $display("[TB] flush and illegal opcode");
    applyStimulus(1'b1, 32'h20010000, 1'b0);
    applyStimulus(1'b1, 32'h20020000, 1'b0);
    applyStimulus(1'b1, 32'h20030000, 1'b0);
    applyStimulus(1'b1, 32'h20040000, 1'b1);
    checkEq("flush_no_accept", 32'(lastReady), 32'd0);
    checkEq("flush_wb_valid", 32'(lastWb), 32'd1);
    checkEq("flush_wb_reg", 32'(lastWbReg), 32'd1);
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkEq("flush_busy_after", 32'(lastBusy), 32'd0);
    checkEq("flush_wb_after", 32'(lastWb), 32'd0);
    applyStimulus(1'b1, BADOP, 1'b0);
    checkEq("bad_illegal", 32'(lastIllegal), 32'd1);
    checkEq("bad_dest", 32'(lastDest), 32'd0);
    checkEq("bad_ready", 32'(lastReady), 32'd1);
    applyStimulus(1'b0, BADOP, 1'b0);
    checkEq("bad_not_valid", 32'(lastIllegal), 32'd0);
    idle(4);

    $display("[TB] asynchronous reset mid-cycle");
    applyStimulus(1'b1, 32'h20050000, 1'b0);
    applyStimulus(1'b1, 32'h20060000, 1'b0);
    #2;
    issue_valid = 1'b0;
    reset = 1'b1;
    #1;
    checkEq("areset_busy", 32'(busy), 32'h0);
    checkEq("areset_wb_valid", 32'(wb_valid), 32'h0);
    @(posedge clk);
    flight.delete();
    cyc++;
    #3;
    reset = 1'b0;
    applyStimulus(1'b1, 32'h20070000, 1'b0);
    checkEq("post_reset_accept", 32'(lastReady), 32'd1);
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkEq("post_reset_busy7", 32'(lastBusy[7]), 32'd1);
    idle(4);

    $display("[TB] random traffic");
    for (int n = 0; n < 400; n++) begin
      randIns = $urandom;
      randIns[31:26] = opTable[$urandom_range(0, 25)];
      randIns[25:21] = 5'($urandom_range(0, 7));
      randIns[20:16] = 5'($urandom_range(0, 7));
      randIns[15:11] = 5'($urandom_range(0, 7));
      if (randIns[31:26] == 6'h01 && $urandom_range(0, 1) == 1)
        randIns[20:16] = ($urandom_range(0, 1) == 1) ? 5'h10 : 5'h11;
      if (randIns[31:26] == 6'h00 && $urandom_range(0, 3) == 0)
        randIns[5:0] = 6'h08;
      applyStimulus(1'($urandom_range(0, 3) != 0), randIns, 1'($urandom_range(0, 15) == 0));
    end
    idle(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
